// File: rtl/sprite_line_engine_if.sv
// Avalon-MM host port of the sprite line engine.
//   chipselect/write/read : transfer strobes from the host bridge
//   address[15:0]         : [9:8] region (attr/pattern/palette/ctrl), low bits word index
//   writedata[31:0]       : write payload
//   readdata[31:0]        : status readback, registered (one cycle after read)
interface sprite_line_engine_if;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [15:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output chipselect, write, read, address, writedata, input readdata);
    modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/sprite_line_engine.sv
// Scanline sprite compositor.
// During horizontal blank a scan FSM walks the attribute table and latches the
// pattern rows of up to MAX_PER_LINE sprites hitting the next line into shadow
// slots; at hcount==1599 the shadow slots become the active slots. During
// active video a 2-stage pipeline picks the winning slot pixel and reads the
// palette.
//   clk, reset          : system clock, async active-high reset
//   bus                 : Avalon-MM slave (tables, control, status)
//   hcount/vcount/blank_n : raster position from vga_counters
//   VGA_R/G/B, VGA_BLANK_n : DAC outputs, 2 cycles behind hcount

// One slot's pixel at the current column; 0 when outside the sprite.
module sle_slot_pix #(
    parameter int SPRITE_W = 16
) (
    input  logic [9:0]  px,
    input  logic [9:0]  x,
    input  logic [31:0] row,
    input  logic        hflip,
    input  logic        valid,
    output logic [1:0]  pix
);
    logic [9:0] dx;
    logic [9:0] p;
    logic [1:0] pix_raw;

    assign dx = px - x;
    assign p  = hflip ? (10'(SPRITE_W - 1) - dx) : dx;

    always_comb begin
        pix_raw = 2'b00;
        for (int k = 0; k < SPRITE_W; k++)
            if (p == 10'(k)) pix_raw = row[2*k +: 2];
    end

    assign pix = (valid && dx < 10'(SPRITE_W)) ? pix_raw : 2'b00;
endmodule

module sprite_line_engine #(
    parameter int NUM_SPRITES  = 16,
    parameter int MAX_PER_LINE = 8,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int PAT_DEPTH    = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_line_engine_if.slave  bus,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 blank_n,
    output logic [7:0]           VGA_R,
    output logic [7:0]           VGA_G,
    output logic [7:0]           VGA_B,
    output logic                 VGA_BLANK_n
);
    localparam int IW = $clog2(NUM_SPRITES);
    localparam int PW = $clog2(PAT_DEPTH);
    localparam int CW = $clog2(MAX_PER_LINE + 1);
    localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, TEST, LOAD, DONE} state_t;

    // ---------------- tables ----------------
    logic [31:0] attr_mem [NUM_SPRITES];
    logic [31:0] pat_mem  [PAT_DEPTH];
    logic [23:0] pal_mem  [16];

    logic [1:0] region;
    logic       host_wr;
    logic       ctrl_wr;
    assign region  = bus.address[9:8];
    assign host_wr = bus.chipselect && bus.write;
    assign ctrl_wr = host_wr && region == 2'b11 && bus.address[7:0] == 8'd0;

    // Reads below sample the arrays in the same edge as the write, so a
    // concurrent read always observes the old word.
    always_ff @(posedge clk) begin
        if (host_wr && region == 2'b00) attr_mem[bus.address[IW-1:0]] <= bus.writedata;
        if (host_wr && region == 2'b01) pat_mem[bus.address[PW-1:0]]  <= bus.writedata;
        if (host_wr && region == 2'b10) pal_mem[bus.address[3:0]]     <= bus.writedata[23:0];
    end

    // ---------------- scan FSM ----------------
    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] sh_cnt, act_cnt;
    logic [9:0]    tline;
    logic [31:0]   attr_q;

    logic [MAX_PER_LINE-1:0][31:0] sh_row, act_row;
    logic [MAX_PER_LINE-1:0][9:0]  sh_x, act_x;
    logic [MAX_PER_LINE-1:0][3:0]  sh_pal, act_pal;
    logic [MAX_PER_LINE-1:0]       sh_flip, act_flip, sh_vld, act_vld;

    logic [9:0]    dy;
    logic [9:0]    pat_sum;
    logic          hit, slot_free, last, scan_start, ovf_set;
    logic [SW-1:0] slot;

    assign dy         = tline - {1'b0, attr_q[8:0]};
    assign hit        = (attr_q[8:0] != 9'h1FF) && (dy < 10'(SPRITE_H));
    assign slot_free  = sh_cnt < CW'(MAX_PER_LINE);
    assign slot       = sh_cnt[SW-1:0];
    assign pat_sum    = {2'b00, attr_q[27:20]} + dy;   // wraps mod PAT_DEPTH via truncation
    assign last       = idx == IW'(NUM_SPRITES - 1);
    assign scan_start = hcount == 11'd1280 && (vcount < 10'd480 || vcount == 10'd524);
    assign ovf_set    = state == TEST && hit && !slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            sh_cnt   <= '0;
            act_cnt  <= '0;
            tline    <= '0;
            attr_q   <= '0;
            sh_row   <= '0;
            sh_x     <= '0;
            sh_pal   <= '0;
            sh_flip  <= '0;
            sh_vld   <= '0;
            act_row  <= '0;
            act_x    <= '0;
            act_pal  <= '0;
            act_flip <= '0;
            act_vld  <= '0;
        end else begin
            case (state)
                IDLE: if (scan_start) begin
                    idx    <= '0;
                    sh_cnt <= '0;
                    tline  <= (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
                    state  <= FETCH;
                end
                FETCH: begin
                    attr_q <= attr_mem[idx];
                    state  <= TEST;
                end
                TEST: begin
                    if (hit && slot_free) state <= LOAD;
                    else if (last)        state <= DONE;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                LOAD: begin
                    sh_row[slot]  <= pat_mem[pat_sum[PW-1:0]];
                    sh_x[slot]    <= attr_q[19:10];
                    sh_pal[slot]  <= attr_q[31:28];
                    sh_flip[slot] <= attr_q[9];
                    sh_vld[slot]  <= 1'b1;
                    sh_cnt        <= sh_cnt + 1'b1;
                    if (last) state <= DONE;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: if (hcount == 11'd1599) begin
                    act_row  <= sh_row;
                    act_x    <= sh_x;
                    act_pal  <= sh_pal;
                    act_flip <= sh_flip;
                    act_vld  <= sh_vld;
                    act_cnt  <= sh_cnt;
                    sh_vld   <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- control / status ----------------
    logic       enable, overflow;
    logic [3:0] cnt4;
    logic [31:0] status;

    always_comb begin
        cnt4 = '0;
        for (int b = 0; b < 4 && b < CW; b++) cnt4[b] = act_cnt[b];
    end
    assign status = {14'd0, vcount, cnt4, 2'b00, overflow, enable};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable       <= 1'b0;
            overflow     <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (ctrl_wr) enable <= bus.writedata[0];
            // a new overflow event beats a same-cycle clear
            if (ovf_set)                          overflow <= 1'b1;
            else if (ctrl_wr && bus.writedata[1]) overflow <= 1'b0;
            if (bus.chipselect && bus.read)
                bus.readdata <= (region == 2'b11) ? status : 32'd0;
        end
    end

    // ---------------- pixel pipeline ----------------
    logic [9:0]                   px;
    logic [MAX_PER_LINE-1:0][1:0] slot_pix;
    logic [3:0]                   win_idx, pal_idx;
    logic [2:1]                   vld_pipe;
    logic [23:0]                  rgb_q;

    assign px = hcount[10:1];

    for (genvar s = 0; s < MAX_PER_LINE; s++) begin : g_slot
        sle_slot_pix #(.SPRITE_W(SPRITE_W)) u_pix (
            .px    (px),
            .x     (act_x[s]),
            .row   (act_row[s]),
            .hflip (act_flip[s]),
            .valid (act_vld[s]),
            .pix   (slot_pix[s])
        );
    end

    // Walk from the highest slot down so the lowest opaque slot wins.
    always_comb begin
        win_idx = 4'd0;
        for (int s = MAX_PER_LINE - 1; s >= 0; s--)
            if (slot_pix[s] != 2'b00) win_idx = act_pal[s] + {2'b00, slot_pix[s]};
        if (!enable) win_idx = 4'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pal_idx  <= '0;
            vld_pipe <= '0;
            rgb_q    <= '0;
        end else begin
            pal_idx  <= win_idx;
            vld_pipe <= {vld_pipe[1], blank_n};
            rgb_q    <= vld_pipe[1] ? pal_mem[pal_idx] : 24'd0;
        end
    end

    assign VGA_R       = rgb_q[7:0];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[23:16];
    assign VGA_BLANK_n = vld_pipe[2];

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.address[15:10], hcount[0]};
endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine: the raster counters are driven
// directly so each check costs one horizontal blank plus a few pixels.
module tb_sprite_line_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        blank_n;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_BLANK_n;

    always #5 clk = ~clk;

    sprite_line_engine_if bus ();

    sprite_line_engine dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n     (blank_n),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_BLANK_n (VGA_BLANK_n)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        int          line;
        int          px;
        logic [23:0] exp_rgb;
    } vec_t;

    localparam logic [23:0] BG = 24'h332211;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd_status(input int v, output logic [31:0] d);
        vcount         = 10'(v);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = 16'h0300;
        tick();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    function automatic logic [31:0] attr(input int y, input int flip, input int x,
                                         input int base, input int pal);
        return {4'(pal), 8'(base), 10'(x), 1'(flip), 9'(y)};
    endfunction

    // Runs one horizontal blank at line v (scan for line v+1, swap at 1599).
    task automatic scan(input int v);
        blank_n = 1'b0;
        vcount  = 10'(v);
        for (int h = 1280; h < 1600; h++) begin
            hcount = 11'(h);
            tick();
        end
        hcount = 11'd0;
    endtask

    task automatic pixel(input int v, input int px, input logic b, output logic [23:0] rgb);
        vcount  = 10'(v);
        hcount  = 11'(2 * px);
        blank_n = b;
        tick();
        tick();
        rgb = {VGA_R, VGA_G, VGA_B};
    endtask

    vec_t        vecs [13];
    logic [23:0] rgb;
    logic [31:0] st;
    logic [31:0] pal_init [16];

    initial begin
        vecs[0]  = '{"single_hit",     50,  100, 24'hFF0000};
        vecs[1]  = '{"single_px101",   50,  101, BG};
        vecs[2]  = '{"single_line49",  49,  100, BG};
        vecs[3]  = '{"priority",      200,  300, 24'h0000FF};
        vecs[4]  = '{"hflip_x15",     300,  415, 24'h808080};
        vecs[5]  = '{"hflip_x0",      300,  400, BG};
        vecs[6]  = '{"y470_line470",  470,   50, 24'h00FF00};
        vecs[7]  = '{"y470_line479",  479,   50, 24'h00FF00};
        vecs[8]  = '{"y470_line469",  469,   50, BG};
        vecs[9]  = '{"y0_from_524",     0,   60, 24'h0000FF};
        vecs[10] = '{"x630_px639",     10,  639, 24'h808080};
        vecs[11] = '{"x630_px629",     10,  629, BG};
        vecs[12] = '{"x630_px630",     10,  630, 24'h808080};

        for (int k = 0; k < 16; k++) pal_init[k] = 32'h000A0B0C;
        pal_init[0] = 32'h00112233;
        pal_init[1] = 32'h0000FF00;
        pal_init[2] = 32'h00FF0000;
        pal_init[3] = 32'h00808080;
        pal_init[5] = 32'h000000FF;
        pal_init[9] = 32'h00123456;

        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        hcount  = '0;
        vcount  = '0;
        blank_n = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        tick();
        check("reset_rgb",      {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("reset_blank_n",  {31'h0, VGA_BLANK_n}, 32'h0);
        check("reset_readdata", bus.readdata, 32'h0);
        reset   = 1'b0;
        blank_n = 1'b0;
        tick();

        for (int k = 0; k < 16; k++)  wr(16'h0000 + 16'(k), attr(9'h1FF, 0, 0, 0, 0));
        for (int k = 0; k < 256; k++) wr(16'h0100 + 16'(k), 32'h0);
        for (int k = 0; k < 16; k++)  wr(16'h0200 + 16'(k), pal_init[k]);

        wr(16'h0000, attr(50, 0, 100, 0, 4));
        wr(16'h0001, attr(200, 0, 300, 1, 0));
        wr(16'h0002, attr(200, 0, 300, 2, 8));
        wr(16'h0003, attr(300, 1, 400, 3, 0));
        wr(16'h0004, attr(470, 0, 50, 16, 0));
        wr(16'h0005, attr(0, 0, 60, 32, 0));
        wr(16'h0006, attr(10, 0, 630, 48, 0));
        wr(16'h0100, 32'h1);
        wr(16'h0101, 32'h2);
        wr(16'h0102, 32'h1);
        wr(16'h0103, 32'h3);
        for (int k = 16; k < 32; k++) wr(16'h0100 + 16'(k), 32'h1);
        wr(16'h0120, 32'h2);
        wr(16'h0130, 32'hFFFFFFFF);

        // Still disabled: background only, status shows one loaded slot.
        scan(49);
        pixel(50, 100, 1'b1, rgb);
        check("disabled_bg", {8'h0, rgb}, {8'h0, BG});
        check("blank_n_delay", {31'h0, VGA_BLANK_n}, 32'h1);
        rd_status(50, st);
        check("status_disabled", st, 32'h00003210);

        wr(16'h0300, 32'h1);

        for (int k = 0; k < 13; k++) begin
            scan(vecs[k].line == 0 ? 524 : vecs[k].line - 1);
            pixel(vecs[k].line, vecs[k].px, 1'b1, rgb);
            check(vecs[k].name, {8'h0, rgb}, {8'h0, vecs[k].exp_rgb});
        end

        // Transparent pixel in sprite 1 exposes sprite 2.
        wr(16'h0101, 32'h0);
        scan(199);
        pixel(200, 300, 1'b1, rgb);
        check("transparency", {8'h0, rgb}, 32'h00563412);

        // Blanked pixel over a sprite is forced to black.
        scan(49);
        pixel(50, 100, 1'b0, rgb);
        check("blank_forces_0", {8'h0, rgb}, 32'h0);
        check("blank_n_low", {31'h0, VGA_BLANK_n}, 32'h0);

        // Palette write reaches the output two cycles after it is issued.
        pixel(50, 100, 1'b1, rgb);
        wr(16'h0205, 32'h000000AA);
        check("pal_wr_plus1_old", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
        tick();
        check("pal_wr_plus2_new", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00AA0000);

        // Ten sprites on line 100, eight slots.
        for (int k = 0; k < 10; k++) wr(16'h0000 + 16'(k), attr(100, 0, 320 + 20 * k, 64, 0));
        for (int k = 64; k < 80; k++) wr(16'h0100 + 16'(k), 32'h1);
        scan(99);
        pixel(100, 320, 1'b1, rgb);
        check("ovf_slot0", {8'h0, rgb}, 32'h0000FF00);
        pixel(100, 460, 1'b1, rgb);
        check("ovf_slot7", {8'h0, rgb}, 32'h0000FF00);
        pixel(100, 480, 1'b1, rgb);
        check("ovf_sprite8_dropped", {8'h0, rgb}, {8'h0, BG});
        pixel(100, 500, 1'b1, rgb);
        check("ovf_sprite9_dropped", {8'h0, rgb}, {8'h0, BG});
        rd_status(100, st);
        check("status_ovf", st, 32'h00006483);
        wr(16'h0300, 32'h3);
        rd_status(100, st);
        check("status_ovf_cleared", st, 32'h00006481);
        scan(99);
        rd_status(100, st);
        check("status_ovf_again", st, 32'h00006483);
        wr(16'h0008, attr(9'h1FF, 0, 0, 0, 0));
        wr(16'h0009, attr(9'h1FF, 0, 0, 0, 0));
        wr(16'h0300, 32'h3);
        scan(99);
        rd_status(100, st);
        check("status_ovf_removed", st, 32'h00006481);

        // Async reset at hcount=600 of line 100.
        pixel(100, 300, 1'b1, rgb);
        reset = 1'b1;
        #1;
        check("async_rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("async_rst_blank", {31'h0, VGA_BLANK_n}, 32'h0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        rd_status(100, st);
        check("status_after_rst", st, 32'h00006400);
        wr(16'h0300, 32'h1);
        pixel(100, 320, 1'b1, rgb);
        check("rst_slots_invalid", {8'h0, rgb}, {8'h0, BG});
        scan(100);
        pixel(101, 320, 1'b1, rgb);
        check("rst_resume", {8'h0, rgb}, 32'h0000FF00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
